pipe_ctrl: RTL and testbench

- Central sequencing controller for the 3-stage RV32I pipeline (fetch -> decode -> execute).
- Owns the instruction-memory request handshake (req/gnt/rvalid) on behalf of fetch.
- Detects load-use hazards from decode's unregistered source fields and generates stall/bubble controls.
- Turns an execute-stage branch mispredict into a timed flush of decode and execute, and counts stall cycles for debug.

---
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 3-stage RV32I pipeline.
//   req                  - pipeline clock (rising edge)
//   reset                - synchronous active-high reset
//   fetch_req_in, gnt_in, instr_rvalid_in / instr_req_out, instr_valid_out
//                        - imem request handshake run on behalf of fetch
//   rs*_unreg_in, rs*_read_unreg_in, ex_rd_in, ex_rd_write_in, ex_mem_read_in
//                        - load-use hazard detection inputs
//   branch_mispredicted_in - execute-stage mispredict pulse
//   stall_fetch_out, stall_decode_out, flush_decode_out, flush_execute_out
//                        - pipeline hold/kill controls
//   timeout_err_out      - sticky: imem never returned data
//   stall_count_out      - free-running count of fetch-stall cycles
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             req,
  input  logic             reset,
  input  logic             fetch_req_in,
  input  logic             gnt_in,
  input  logic             instr_rvalid_in,
  output logic             instr_req_out,
  output logic             instr_valid_out,
  input  logic [4:0]       rs1_unreg_in,
  input  logic             rs1_read_unreg_in,
  input  logic [4:0]       rs2_unreg_in,
  input  logic             rs2_read_unreg_in,
  input  logic [4:0]       ex_rd_in,
  input  logic             ex_rd_write_in,
  input  logic             ex_mem_read_in,
  input  logic             branch_mispredicted_in,
  output logic             stall_fetch_out,
  output logic             stall_decode_out,
  output logic             flush_decode_out,
  output logic             flush_execute_out,
  output logic             timeout_err_out,
  output logic [CNT_W-1:0] stall_count_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t     state, state_d;
  logic [7:0] wait_cnt;
  logic [3:0] flush_cnt;
  logic       drop_q, drop_d;
  logic       timeout_hit;
  logic       hazard, flush_active, stall, can_issue;

  assign hazard = ex_mem_read_in & ex_rd_write_in & (ex_rd_in != 5'd0) &
                  ((rs1_read_unreg_in & (rs1_unreg_in == ex_rd_in)) |
                   (rs2_read_unreg_in & (rs2_unreg_in == ex_rd_in)));

  // The mispredict pulse itself covers the first flush cycle.
  assign flush_active = (flush_cnt != 4'd0) | branch_mispredicted_in;

  // A hazarding instruction that is being flushed must not stall the pipe.
  assign stall     = hazard & ~flush_active;
  assign can_issue = fetch_req_in & ~stall & ~flush_active;

  assign stall_fetch_out   = stall;
  assign stall_decode_out  = stall;
  assign flush_decode_out  = flush_active;
  assign flush_execute_out = flush_active | hazard;

  assign instr_req_out   = (state == S_REQ);
  assign instr_valid_out = instr_rvalid_in & (state == S_WAIT) & ~drop_q;

  always_comb begin
    state_d     = state;
    drop_d      = drop_q;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_issue) state_d = S_REQ;
      end
      S_REQ: begin
        // A grant coinciding with a mispredict still completes the access;
        // its data is dropped on return.
        if (gnt_in) begin
          state_d = S_WAIT;
          if (branch_mispredicted_in) drop_d = 1'b1;
        end else if (branch_mispredicted_in) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (instr_rvalid_in) begin
          drop_d  = 1'b0;
          state_d = can_issue ? S_REQ : S_IDLE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          drop_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (branch_mispredicted_in) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge req) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      flush_cnt       <= '0;
      drop_q          <= 1'b0;
      timeout_err_out <= 1'b0;
      stall_count_out <= '0;
    end else begin
      state    <= state_d;
      drop_q   <= drop_d;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 8'd1 : '0;
      if (branch_mispredicted_in)
        flush_cnt <= 4'(FLUSH_CYCLES);
      else if (flush_cnt != 4'd0)
        flush_cnt <= flush_cnt - 4'd1;
      if (timeout_hit) timeout_err_out <= 1'b1;
      stall_count_out <= stall_count_out + CNT_W'(stall);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl,
// checked every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int FLUSH = 2;
  localparam int TMO   = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset, fetch_req, gnt, rvalid, mp;
  logic [4:0]    rs1, rs2, exrd;
  logic          rs1_rd, rs2_rd, exwr, exmem;
  logic          instr_req_out, instr_valid_out;
  logic          stall_fetch_out, stall_decode_out;
  logic          flush_decode_out, flush_execute_out, timeout_err_out;
  logic [CW-1:0] stall_count_out;

  int checks   = 0;
  int failures = 0;

  // Model state: what the controller is doing, in transaction terms.
  bit            m_known;
  bit            m_requesting, m_waiting, m_drop, m_err;
  int            m_age, m_flush_left;
  logic [CW-1:0] m_stalls;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .req                    (clk),
    .reset                  (reset),
    .fetch_req_in           (fetch_req),
    .gnt_in                 (gnt),
    .instr_rvalid_in        (rvalid),
    .instr_req_out          (instr_req_out),
    .instr_valid_out        (instr_valid_out),
    .rs1_unreg_in           (rs1),
    .rs1_read_unreg_in      (rs1_rd),
    .rs2_unreg_in           (rs2),
    .rs2_read_unreg_in      (rs2_rd),
    .ex_rd_in               (exrd),
    .ex_rd_write_in         (exwr),
    .ex_mem_read_in         (exmem),
    .branch_mispredicted_in (mp),
    .stall_fetch_out        (stall_fetch_out),
    .stall_decode_out       (stall_decode_out),
    .flush_decode_out       (flush_decode_out),
    .flush_execute_out      (flush_execute_out),
    .timeout_err_out        (timeout_err_out),
    .stall_count_out        (stall_count_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; fetch_req = 0; gnt = 0; rvalid = 0; mp = 0;
    rs1 = 0; rs2 = 0; exrd = 0; rs1_rd = 0; rs2_rd = 0; exwr = 0; exmem = 0;
  endtask

  // Compare the current cycle against the model, then advance the model
  // and the clock. Inputs are applied just after a falling edge.
  task automatic tick();
    bit haz, fl, st, issue;
    #1;
    haz = exmem && exwr && exrd != 0 &&
          ((rs1_rd && rs1 == exrd) || (rs2_rd && rs2 == exrd));
    fl    = (m_flush_left > 0) || mp;
    st    = haz && !fl;
    issue = fetch_req && !st && !fl;
    if (m_known) begin
      check("instr_req",   instr_req_out,     m_requesting);
      check("instr_valid", instr_valid_out,   m_waiting && rvalid && !m_drop);
      check("stall_fetch", stall_fetch_out,   st);
      check("stall_dec",   stall_decode_out,  st);
      check("flush_dec",   flush_decode_out,  fl);
      check("flush_ex",    flush_execute_out, fl || haz);
      check("timeout_err", timeout_err_out,   m_err);
      check("stall_count", stall_count_out,   m_stalls);
    end
    if (reset) begin
      m_known = 1; m_requesting = 0; m_waiting = 0; m_drop = 0; m_err = 0;
      m_age = 0; m_flush_left = 0; m_stalls = '0;
    end else begin
      m_stalls     = m_stalls + (st ? 1 : 0);
      m_flush_left = mp ? FLUSH : (m_flush_left > 0 ? m_flush_left - 1 : 0);
      if (m_requesting) begin
        if (gnt) begin
          m_requesting = 0; m_waiting = 1; m_age = 0; m_drop = mp;
        end else if (mp) begin
          m_requesting = 0;
        end
      end else if (m_waiting) begin
        if (rvalid) begin
          m_waiting = 0; m_drop = 0; m_requesting = issue;
        end else if (m_age + 1 == TMO) begin
          m_waiting = 0; m_drop = 0; m_err = 1;
        end else begin
          m_age++;
          if (mp) m_drop = 1;
        end
      end else begin
        m_requesting = issue;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    m_known = 0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Basic fetch: gnt at cycle 1, rvalid at cycle 3, re-request at cycle 4.
    #1; check("rst_req", instr_req_out, 0); check("rst_cnt", stall_count_out, 0);
    check("rst_err", timeout_err_out, 0);
    fetch_req = 1; tick();
    gnt = 1; #1; check("c1_req", instr_req_out, 1); tick();
    gnt = 0; #1; check("c2_req", instr_req_out, 0); check("c2_valid", instr_valid_out, 0); tick();
    rvalid = 1; #1; check("c3_valid", instr_valid_out, 1); tick();
    rvalid = 0; #1; check("c4_req", instr_req_out, 1); tick();
    fetch_req = 0; gnt = 1; tick();
    gnt = 0; rvalid = 1; tick(); rvalid = 0;

    // Load-use on rs2, then the same pattern against x0.
    exmem = 1; exwr = 1; exrd = 5; rs2 = 5; rs2_rd = 1;
    #1; check("lu_stall", stall_fetch_out, 1); check("lu_flush_ex", flush_execute_out, 1); tick();
    idle_inputs(); #1; check("lu_count", stall_count_out, 1); tick();
    exmem = 1; exwr = 1; exrd = 0; rs2 = 0; rs2_rd = 1;
    #1; check("x0_stall", stall_fetch_out, 0); tick();

    // Mispredict with concurrent hazard, second pulse one cycle later.
    exrd = 7; rs1 = 7; rs1_rd = 1; mp = 1;
    #1; check("mp0_flush", flush_decode_out, 1); check("mp0_stall", stall_fetch_out, 0); tick();
    #1; check("mp1_flush", flush_execute_out, 1); tick();
    mp = 0; #1; check("mp2_flush", flush_decode_out, 1); tick();
    #1; check("mp3_flush", flush_decode_out, 1); tick();
    idle_inputs(); #1; check("mp4_flush", flush_decode_out, 0); tick();

    // Mispredict during WAIT: the returning data is dropped.
    fetch_req = 1; tick(); gnt = 1; tick(); gnt = 0;
    mp = 1; tick(); mp = 0; tick();
    rvalid = 1; #1; check("drop_valid", instr_valid_out, 0); check("drop_req", instr_req_out, 0); tick();
    rvalid = 0; fetch_req = 0; #1; check("drop_req2", instr_req_out, 0); tick();

    // Timeout: no rvalid for TMO cycles after entering WAIT.
    do_reset(); fetch_req = 1; tick(); fetch_req = 0; gnt = 1; tick(); gnt = 0;
    for (int k = 0; k < TMO; k++) begin
      #1; check("tmo_pre", timeout_err_out, 0); tick();
    end
    #1; check("tmo_err", timeout_err_out, 1); check("tmo_req", instr_req_out, 0); tick();
    rvalid = 1; #1; check("tmo_late_valid", instr_valid_out, 0); tick(); rvalid = 0;
    repeat (5) tick();
    #1; check("tmo_sticky", timeout_err_out, 1); tick();

    // Reset while waiting; a late rvalid must be ignored.
    do_reset(); fetch_req = 1; tick(); fetch_req = 0; gnt = 1; tick(); gnt = 0; tick();
    reset = 1; tick(); reset = 0;
    rvalid = 1; #1;
    check("rw_valid", instr_valid_out, 0); check("rw_req", instr_req_out, 0);
    check("rw_cnt", stall_count_out, 0); check("rw_err", timeout_err_out, 0);
    check("rw_flush", flush_decode_out, 0);
    tick(); rvalid = 0;

    // Random traffic with alternating responsive and sluggish memory.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      int rv_pct;
      rv_pct    = ((cyc / 250) % 2 == 0) ? 40 : 3;
      reset     = ($urandom_range(299) == 0);
      fetch_req = ($urandom_range(99) < 80);
      gnt       = ($urandom_range(99) < 50);
      rvalid    = ($urandom_range(99) < rv_pct);
      mp        = ($urandom_range(99) < 6);
      rs1       = 5'($urandom_range(3));
      rs2       = 5'($urandom_range(3));
      exrd      = 5'($urandom_range(3));
      rs1_rd    = $urandom_range(1);
      rs2_rd    = $urandom_range(1);
      exwr      = ($urandom_range(99) < 80);
      exmem     = ($urandom_range(99) < 40);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
